// File: rtl/alu_pkg.sv
// Shared constants for the Booth/restoring-division ALU datapath:
// control-bit positions, opcode codes and the datapath width.
package alu_pkg;

  localparam int WIDTH = 8;

  localparam int C0_IDX  = 0;
  localparam int C1_IDX  = 1;
  localparam int C2_IDX  = 2;
  localparam int C3_IDX  = 3;
  localparam int C4_IDX  = 4;
  localparam int C5_IDX  = 5;
  localparam int C6_IDX  = 6;
  localparam int C7_IDX  = 7;
  localparam int C8_IDX  = 8;
  localparam int C9_IDX  = 9;
  localparam int C10_IDX = 10;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef logic [WIDTH-1:0] word_t;

endpackage

// File: rtl/alu_datapath_if.sv
// Bus between the control unit and the ALU datapath.
// Optional feature macro: ALU_OVF_EN adds the ovf status line.
interface alu_datapath_if;

  logic [alu_pkg::WIDTH-1:0] inbus;
  logic [10:0]               control;
  logic                      Q0;
  logic                      Q_1;
  logic                      A7;
  logic                      count;
  logic [alu_pkg::WIDTH-1:0] outbus;
  logic                      out_valid;
`ifdef ALU_OVF_EN
  logic                      ovf;
`endif

  modport master (
    output inbus, control,
    input  Q0, Q_1, A7, count, outbus, out_valid
`ifdef ALU_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  inbus, control,
    output Q0, Q_1, A7, count, outbus, out_valid
`ifdef ALU_OVF_EN
    , output ovf
`endif
  );

endinterface

// File: rtl/add_sub8.sv
// 8-bit adder/subtractor; subtraction is A + ~B + 1.
// Optional feature macro: ALU_OVF_EN adds the signed-overflow output.
module add_sub8
  import alu_pkg::*;
(
  input  word_t a,
  input  word_t b,
  input  logic  sub,
  output word_t sum,
  output logic  carry
`ifdef ALU_OVF_EN
  , output logic ovf
`endif
);

  word_t      b_eff;
  logic [8:0] full;

  assign b_eff = sub ? ~b : b;
  assign full  = {1'b0, a} + {1'b0, b_eff} + {8'd0, sub};
  assign sum   = full[7:0];
  assign carry = full[8];

`ifdef ALU_OVF_EN
  // Signed overflow: operands agree in sign but the result does not.
  assign ovf = (a[7] == b_eff[7]) && (sum[7] != a[7]);
`endif

endmodule

// File: rtl/alu_datapath.sv
// Shift/add datapath (A, Q, M, Q_1, qbit, step counter) driven by an 11-bit
// control word. Optional feature macro: ALU_OVF_EN adds the ovf flag.
module alu_datapath
  import alu_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  alu_datapath_if.slave  bus
);

  word_t      a_reg;
  word_t      q_reg;
  word_t      m_reg;
  logic       q_1;
  logic       qbit;
  logic [2:0] cnt;
  word_t      out_reg;
  logic       valid_reg;

  logic [10:0] c;
  logic        arith_we;
  word_t       sum;
  logic        unused_carry;
`ifdef ALU_OVF_EN
  logic        add_ovf;
  logic        ovf_reg;
`endif

  assign c        = bus.control;
  assign arith_we = c[C3_IDX] | c[C4_IDX] | c[C5_IDX];

  add_sub8 u_add_sub8 (
    .a     (a_reg),
    .b     (m_reg),
    .sub   (c[C5_IDX]),
    .sum   (sum),
    .carry (unused_carry)
`ifdef ALU_OVF_EN
    , .ovf (add_ovf)
`endif
  );

  // A-register writes are prioritised C2 > add/sub > right shift > left shift;
  // a losing shift also drops its Q/Q_1 side effects, and C0 suppresses shifts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg     <= '0;
      q_reg     <= '0;
      m_reg     <= '0;
      q_1       <= 1'b0;
      qbit      <= 1'b0;
      cnt       <= '0;
      out_reg   <= '0;
      valid_reg <= 1'b0;
    end else begin
      if (c[C2_IDX]) begin
        a_reg <= '0;
      end else if (arith_we) begin
        a_reg <= sum;
        if (c[C5_IDX])
          qbit <= ~sum[7];
      end else if (c[C6_IDX] && !c[C0_IDX]) begin
        a_reg <= {a_reg[7], a_reg[7:1]};
        q_reg <= {a_reg[0], q_reg[7:1]};
        q_1   <= q_reg[0];
      end else if (c[C7_IDX] && !c[C0_IDX]) begin
        a_reg <= {a_reg[6:0], q_reg[7]};
        q_reg <= {q_reg[6:0], qbit};
      end

      if (c[C0_IDX]) begin
        q_reg <= bus.inbus;
        q_1   <= 1'b0;
        qbit  <= 1'b0;
      end

      if (c[C1_IDX])
        m_reg <= bus.inbus;

      if (c[C0_IDX])
        cnt <= '0;
      else if (c[C8_IDX])
        cnt <= cnt + 3'd1;

      // Result capture sees pre-edge A/Q, so it can share a cycle with a shift.
      if (c[C10_IDX])
        out_reg <= q_reg;
      else if (c[C9_IDX])
        out_reg <= a_reg;
      valid_reg <= c[C9_IDX] | c[C10_IDX];
    end
  end

`ifdef ALU_OVF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      ovf_reg <= 1'b0;
    else if (c[C0_IDX])
      ovf_reg <= 1'b0;
    else if (arith_we)
      ovf_reg <= add_ovf;
  end

  assign bus.ovf = ovf_reg;
`endif

  assign bus.Q0        = q_reg[0];
  assign bus.Q_1       = q_1;
  assign bus.A7        = a_reg[7];
  assign bus.count     = (cnt == 3'd7);
  assign bus.outbus    = out_reg;
  assign bus.out_valid = valid_reg;

endmodule
